// File: rtl/demux32_pkg.sv
// demux32_pkg: shared definitions for the 32-bit serial-to-parallel receiver.
//   NBITS       - bits per assembled word
//   SELW        - width of the bit index / transmitter select
//   sel_t       - bit index type
//   word_t      - assembled word type
//   LAST_SEL    - index of the final bit of a word
//   buf_state_t - output buffer state (COLLECT = empty, HOLD = word held)
package demux32_pkg;

  localparam int NBITS = 32;
  localparam int SELW  = 5;

  typedef logic [SELW-1:0]  sel_t;
  typedef logic [NBITS-1:0] word_t;

  localparam sel_t LAST_SEL = sel_t'(NBITS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } buf_state_t;

endpackage

// File: rtl/out_buf32.sv
// out_buf32: single-entry valid/ready register slice for assembled words.
// Handshake: a word is transferred downstream on any rising edge where
// out_valid & out_ready; out_valid stays high until that transfer happens.
// A load in the same cycle as a drain replaces the word with no bubble.
// Ports:
//   clk, rst   - clock, synchronous active-low reset
//   load       - a complete word is offered on load_data this cycle
//   load_data  - word to capture
//   out_ready  - downstream consumes the held word
//   out_valid  - a word is held (equals state == HOLD)
//   out_data   - held word; keeps its value after a drain
//   state      - debug view of the buffer state (buf_state_t encoding)
module out_buf32
  import demux32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [NBITS-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [NBITS-1:0] out_data,
  output logic             state
);

  buf_state_t state_q;
  buf_state_t state_d;
  word_t      data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= COLLECT;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= load_data;
      end
    end
  end

  // Load wins over drain: a drain coinciding with a load keeps HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (load) state_d = HOLD;
      HOLD: begin
        if (load)           state_d = HOLD;
        else if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign state     = state_q;

endmodule

// File: rtl/demux32_deser.sv
// demux32_deser: receiver for a counter-driven mux32 serial link. Drives the
// transmitter select with cur_sel, accepts one bit per handshake into
// acc[cur_sel], and hands completed words to a one-word output buffer.
// Handshake (both sides): a transfer happens on a rising edge where
// valid & ready are both high. in_ready depends combinationally on
// out_ready only, never on in_valid.
// Ports:
//   clk, rst   - clock, synchronous active-low reset
//   flush      - abort the partial word (output buffer untouched)
//   in_valid   - in_bit holds a valid serial bit
//   in_bit     - serial bit (mux32 y)
//   in_ready   - bit accepted this cycle when in_valid is high
//   cur_sel    - index of the next expected bit (drives mux32 sel)
//   out_valid  - out_data holds a complete word
//   out_data   - assembled word
//   out_ready  - downstream consumes out_data
//   word_cnt   - words moved into the output buffer, wraps silently
//   overrun    - sticky: a bit was offered while in_ready was low
module demux32_deser
  import demux32_pkg::*;
#(
  parameter int W_CNT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [SELW-1:0]  cur_sel,
  output logic             out_valid,
  output logic [NBITS-1:0] out_data,
  input  logic             out_ready,
  output logic [W_CNT-1:0] word_cnt,
  output logic             overrun
);

  sel_t             sel_q;
  word_t            acc_q;
  word_t            acc_d;
  logic [W_CNT-1:0] cnt_q;
  logic             ovr_q;
  logic             accept;
  logic             complete;
  logic             buf_state;
  word_t            load_word;

  // Only the final bit can be blocked: bits 0..30 keep flowing into acc
  // while a previous word is still waiting downstream.
  assign in_ready = ~((sel_q == LAST_SEL) & (buf_state == HOLD) & ~out_ready);

  // flush drops any bit offered alongside it.
  assign accept   = in_valid & in_ready & ~flush;
  assign complete = accept & (sel_q == LAST_SEL);

  // The final bit bypasses acc and goes straight into the buffer.
  assign load_word = {in_bit, acc_q[NBITS-2:0]};

  always_comb begin
    acc_d = acc_q;
    if (flush || complete) begin
      acc_d = '0;
    end else if (accept) begin
      acc_d[sel_q] = in_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (flush) begin
        sel_q <= '0;
      end else if (accept) begin
        sel_q <= sel_q + sel_t'(1);  // 31 wraps to 0
      end
      if (complete) begin
        cnt_q <= cnt_q + {{(W_CNT-1){1'b0}}, 1'b1};
      end
      if (in_valid && !in_ready) begin
        ovr_q <= 1'b1;
      end
    end
  end

  out_buf32 u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (complete),
    .load_data (load_word),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .state     (buf_state)
  );

  assign cur_sel  = sel_q;
  assign word_cnt = cnt_q;
  assign overrun  = ovr_q;

endmodule
